// File: rtl/me_pkg.sv
// Shared types and constants for the memory stage and its write-back register.
package me_pkg;

   typedef enum logic {
      StIdle   = 1'b0,
      StAccess = 1'b1
   } me_state_e;

   localparam logic [31:0] NOP_INSTR              = 32'h0000_0020;
   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/me_wb.sv
// ME/WB pipeline register; a bubble load writes a NOP with no register write.
module me_wb
   import me_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bubble,
   input  logic [31:0] result,
   input  logic [4:0]  td,
   input  logic        wreg,
   input  logic [31:0] instr,
   output logic [31:0] wb_result,
   output logic [4:0]  wb_td,
   output logic        wb_WREG,
   output logic [31:0] wb_instr
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_result <= '0;
         wb_td     <= '0;
         wb_WREG   <= 1'b0;
         wb_instr  <= NOP_INSTR;
      end else if (bubble) begin
         wb_result <= '0;
         wb_td     <= '0;
         wb_WREG   <= 1'b0;
         wb_instr  <= NOP_INSTR;
      end else begin
         wb_result <= result;
         wb_td     <= td;
         wb_WREG   <= wreg;
         wb_instr  <= instr;
      end
   end

endmodule

// File: rtl/me_stage.sv
// Memory pipeline stage: IDLE/ACCESS handshake with data memory, stalls upstream while busy.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module me_stage
   import me_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] me_aluresult,
   input  logic [31:0] me_d2,
   input  logic [4:0]  me_td,
   input  logic        me_WREG,
   input  logic        me_WMEM,
   input  logic        me_LW,
   input  logic [31:0] me_instr,
   output logic        me_stall,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic [31:0] wb_result,
   output logic [4:0]  wb_td,
   output logic        wb_WREG,
   output logic [31:0] wb_instr,
   output logic        me_err
);

   me_state_e   state_q, state_d;
   logic        mem_op;
   logic        timeout;
   logic        wb_bubble;
   logic [31:0] wb_src;

   assign mem_op   = me_WMEM | me_LW;
   assign dm_addr  = me_aluresult;
   assign dm_wdata = me_d2;

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            err_q;

   // Counter holds the number of ACCESS cycles already completed; zero on entry.
   assign timeout = (state_q == StAccess) && !dm_ack &&
                    (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = '0;
      if (state_q == StAccess) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_q | timeout;
      end
   end

   assign me_err = err_q;
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = |TIMEOUT_CYCLES;
   assign timeout            = 1'b0;
   assign me_err             = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      me_stall  = 1'b0;
      wb_bubble = 1'b0;
      wb_src    = me_aluresult;
      dm_req    = 1'b0;
      dm_we     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (mem_op) begin
               me_stall  = 1'b1;
               wb_bubble = 1'b1;
               state_d   = StAccess;
            end
         end
         StAccess: begin
            dm_req = 1'b1;
            dm_we  = me_WMEM;
            if (dm_ack) begin
               state_d = StIdle;
               // A combined load/store behaves as a store.
               if (me_LW && !me_WMEM) begin
                  wb_src = dm_rdata;
               end
            end else if (timeout) begin
               state_d   = StIdle;
               wb_bubble = 1'b1;
            end else begin
               me_stall  = 1'b1;
               wb_bubble = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   me_wb u_me_wb (
      .clk       (clk),
      .rst_n     (rst_n),
      .bubble    (wb_bubble),
      .result    (wb_src),
      .td        (me_td),
      .wreg      (me_WREG),
      .instr     (me_instr),
      .wb_result (wb_result),
      .wb_td     (wb_td),
      .wb_WREG   (wb_WREG),
      .wb_instr  (wb_instr)
   );

endmodule

// File: tb/tb_me_stage.sv
// Scoreboard bench for me_stage: driver pushes expected write-back values, monitor pops them.
module tb_me_stage;

   typedef struct packed {
      logic [31:0] result;
      logic [4:0]  td;
      logic        wreg;
      logic [31:0] instr;
   } wb_t;

   localparam logic [31:0] NOP    = 32'h0000_0020;
   localparam wb_t         BUBBLE = '{result: 32'h0, td: 5'h0, wreg: 1'b0, instr: NOP};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] me_aluresult = '0;
   logic [31:0] me_d2 = '0;
   logic [4:0]  me_td = '0;
   logic        me_WREG = 1'b0;
   logic        me_WMEM = 1'b0;
   logic        me_LW = 1'b0;
   logic [31:0] me_instr = NOP;
   logic        me_stall;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_ack = 1'b0;
   logic [31:0] dm_rdata = '0;
   logic [31:0] wb_result;
   logic [4:0]  wb_td;
   logic        wb_WREG;
   logic [31:0] wb_instr;
   logic        me_err;

   int  checks = 0;
   int  errors = 0;
   wb_t exp_q[$];
   wb_t mon_e;

   me_stage #(
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .me_aluresult (me_aluresult),
      .me_d2        (me_d2),
      .me_td        (me_td),
      .me_WREG      (me_WREG),
      .me_WMEM      (me_WMEM),
      .me_LW        (me_LW),
      .me_instr     (me_instr),
      .me_stall     (me_stall),
      .dm_req       (dm_req),
      .dm_we        (dm_we),
      .dm_addr      (dm_addr),
      .dm_wdata     (dm_wdata),
      .dm_ack       (dm_ack),
      .dm_rdata     (dm_rdata),
      .wb_result    (wb_result),
      .wb_td        (wb_td),
      .wb_WREG      (wb_WREG),
      .wb_instr     (wb_instr),
      .me_err       (me_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic [31:0] alu, input logic [31:0] d2, input logic [4:0] td,
                         input logic wreg, input logic wmem, input logic lw,
                         input logic [31:0] instr);
      me_aluresult = alu;
      me_d2        = d2;
      me_td        = td;
      me_WREG      = wreg;
      me_WMEM      = wmem;
      me_LW        = lw;
      me_instr     = instr;
   endtask

   // Called at a falling edge; checks combinational outputs, queues the write-back
   // expected after the next rising edge, then advances to the next falling edge.
   task automatic cyc(input string tag, input logic ack, input logic [31:0] rdata,
                      input logic stall, input logic req, input logic we, input wb_t exp);
      dm_ack   = ack;
      dm_rdata = rdata;
      #1;
      chk({tag, " me_stall"}, {31'b0, me_stall}, {31'b0, stall});
      chk({tag, " dm_req"}, {31'b0, dm_req}, {31'b0, req});
      chk({tag, " dm_we"}, {31'b0, dm_we}, {31'b0, we});
      if (req) chk({tag, " dm_addr"}, dm_addr, me_aluresult);
      if (we) chk({tag, " dm_wdata"}, dm_wdata, me_d2);
      exp_q.push_back(exp);
      @(negedge clk);
   endtask

   always begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         checks++;
         if ({wb_result, wb_td, wb_WREG, wb_instr} !== mon_e) begin
            errors++;
            $display("FAIL wb: got result=%h td=%0d wreg=%b instr=%h expected result=%h td=%0d wreg=%b instr=%h",
                     wb_result, wb_td, wb_WREG, wb_instr,
                     mon_e.result, mon_e.td, mon_e.wreg, mon_e.instr);
         end
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      #1;
      chk("reset wb_result", wb_result, 32'h0);
      chk("reset wb_td", {27'b0, wb_td}, 32'h0);
      chk("reset wb_WREG", {31'b0, wb_WREG}, 32'h0);
      chk("reset wb_instr", wb_instr, NOP);
      chk("reset dm_req", {31'b0, dm_req}, 32'h0);
      chk("reset me_err", {31'b0, me_err}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Plain ALU op, then one with a stray ack in IDLE that must be ignored
      set_in(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0000_0113);
      cyc("alu", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '{32'h1234, 5'd5, 1'b1, 32'h0000_0113});
      set_in(32'hA5A5_0000, 32'h0, 5'd31, 1'b0, 1'b0, 1'b0, 32'h0000_0213);
      cyc("alu ack", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0,
          '{32'hA5A5_0000, 5'd31, 1'b0, 32'h0000_0213});

      // Load with ack three cycles after the request
      set_in(32'h100, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 32'h0000_0383);
      cyc("ld idle", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, BUBBLE);
      for (int i = 0; i < 3; i++) cyc("ld wait", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, BUBBLE);
      cyc("ld ack", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0,
          '{32'hDEAD_BEEF, 5'd7, 1'b1, 32'h0000_0383});

      // Back-to-back store with immediate ack re-enters through IDLE
      set_in(32'h40, 32'h55, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0023);
      cyc("st idle", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, BUBBLE);
      cyc("st ack", 1'b1, 32'h1111_1111, 1'b0, 1'b1, 1'b1,
          '{32'h40, 5'd0, 1'b0, 32'h0000_0023});

      // Load and store together behave as a store
      set_in(32'h80, 32'h77, 5'd3, 1'b1, 1'b1, 1'b1, 32'h0000_00A3);
      cyc("ldst idle", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, BUBBLE);
      cyc("ldst ack", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1,
          '{32'h80, 5'd3, 1'b1, 32'h0000_00A3});

      // Reset during the second ACCESS cycle
      set_in(32'h200, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 32'h0000_0483);
      cyc("rst idle", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, BUBBLE);
      cyc("rst acc1", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, BUBBLE);
      rst_n = 1'b0;
      #1;
      chk("rst dm_req", {31'b0, dm_req}, 32'h0);
      chk("rst wb_instr", wb_instr, NOP);
      chk("rst wb_WREG", {31'b0, wb_WREG}, 32'h0);
      @(negedge clk);
      set_in(32'h0BEE, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0000_0513);
      rst_n = 1'b1;
      cyc("post rst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '{32'h0BEE, 5'd2, 1'b1, 32'h0000_0513});

      // Load that is never acknowledged
      set_in(32'h300, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 32'h0000_0603);
      cyc("to idle", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, BUBBLE);
`ifdef MEM_TIMEOUT_EN
      for (int i = 0; i < 3; i++) cyc("to wait", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, BUBBLE);
      cyc("to abort", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, BUBBLE);
      chk("to me_err", {31'b0, me_err}, 32'h1);
      set_in(32'h77, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0000_0713);
      cyc("to after", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '{32'h77, 5'd6, 1'b1, 32'h0000_0713});
      chk("to me_err sticky", {31'b0, me_err}, 32'h1);
`else
      for (int i = 0; i < 10; i++) cyc("to wait", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, BUBBLE);
      chk("to me_err", {31'b0, me_err}, 32'h0);
      cyc("to ack", 1'b1, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b0,
          '{32'h0BAD_F00D, 5'd4, 1'b1, 32'h0000_0603});
`endif

      set_in(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, NOP);
      repeat (3) @(negedge clk);
      chk("queue drained", exp_q.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/me_stage.md
ME_STAGE -- requirements
Module: me_stage

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, max ACCESS-state cycles before abort (used only with MEM_TIMEOUT_EN).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 me_aluresult  in  32  ALU result / memory address from EX/ME register.
REQ-005 me_d2  in  32  store data.
REQ-006 me_td  in  5  destination register number.
REQ-007 me_WREG, me_WMEM, me_LW  in  1 each  register-write, memory-write and load controls.
REQ-008 me_instr  in  32  instruction tag carried down the pipe.
REQ-009 me_stall  out  1  combinational; high = upstream SHALL hold all me_* inputs.
REQ-010 dm_req, dm_we  out  1 each  data-memory request, write enable.
REQ-011 dm_addr, dm_wdata  out  32 each  memory address, write data.
REQ-012 dm_ack  in  1  memory completion, sampled only in ACCESS.
REQ-013 dm_rdata  in  32  load data, valid when dm_ack=1.
REQ-014 wb_result  out  32  registered write-back value.
REQ-015 wb_td  out  5; wb_WREG  out  1; wb_instr  out  32  registered write-back controls.
REQ-016 me_err  out  1  sticky memory-timeout flag.

Function
REQ-017 States: IDLE, ACCESS; mem op = me_WMEM | me_LW.
REQ-018 IDLE, no mem op: me_stall=0; next edge wb_result<=me_aluresult, wb_td<=me_td, wb_WREG<=me_WREG, wb_instr<=me_instr (latency 1).
REQ-019 IDLE, mem op: me_stall=1, wb_* load bubble (wb_WREG=0, wb_instr=32'h0000_0020, wb_result=0, wb_td=0), state->ACCESS.
REQ-020 ACCESS: dm_req=1, dm_we=me_WMEM, dm_addr=me_aluresult, dm_wdata=me_d2; dm_req=0 and dm_we=0 in IDLE.
REQ-021 ACCESS with dm_ack=0: me_stall=1, bubble into wb_*, stay ACCESS.
REQ-022 ACCESS with dm_ack=1: me_stall=0; wb_result<=dm_rdata if me_LW else me_aluresult; other wb_* from me_*; state->IDLE.
REQ-023 Minimum mem op occupancy 2 cycles; back-to-back mem ops each re-enter via IDLE.
REQ-024 dm_ack in IDLE SHALL be ignored.
REQ-025 me_WMEM and me_LW both high: treated as store (dm_we=1), wb_result=me_aluresult.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, dm_req=0, me_err=0, wb_result=0, wb_td=0, wb_WREG=0, wb_instr=32'h0000_0020.
REQ-027 Reset during ACCESS SHALL abandon the access; no write-back of that op.

Configuration
REQ-028 Macro MEM_TIMEOUT_EN defined: cycle counter runs in ACCESS, clears on entry; reaching TIMEOUT_CYCLES without dm_ack SHALL return to IDLE, drop dm_req, set me_err=1 until reset, write bubble, me_stall=0 that cycle.
REQ-029 Macro undefined: no counter; ACCESS waits indefinitely; me_err tied 0.

Structure
REQ-030 Shared package me_pkg: state enum, NOP_INSTR=32'h0000_0020, TIMEOUT_CYCLES default.
REQ-031 One sub-module me_wb: registered ME/WB pipeline register with bubble-load input; FSM and memory handshake in me_stage.

Verification
REQ-032 ALU op me_aluresult=32'h1234, me_td=5, me_WREG=1 in IDLE -> next cycle wb_result=32'h1234, wb_td=5, wb_WREG=1, me_stall=0 throughout.
REQ-033 Load addr 32'h100, dm_ack 3 cycles after dm_req, dm_rdata=32'hDEADBEEF -> me_stall high 4 cycles, 4 bubbles, then wb_result=32'hDEADBEEF.
REQ-034 Store addr 32'h40, d2=32'h55, immediate ack -> dm_we=1, dm_wdata=32'h55 for 1 cycle, me_stall high 1 cycle, wb_WREG=0.
REQ-035 rst_n low in second ACCESS cycle -> dm_req=0 at once, wb_instr=32'h0000_0020, state IDLE after release.
REQ-036 With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> dm_req drops after 4 ACCESS cycles, me_err=1 sticky, me_stall=0, wb bubble.
